// File: rtl/ula_mul_seq.sv
// Sequential 64-bit shift-and-add multiplier that borrows the execute-stage ULA for one add per cycle.
// Optional macro ULA_MUL_EARLY_EXIT_EN ends the run as soon as the remaining multiplier bits are zero.
module ula_mul_seq #(
  parameter int          WIDTH = 64,
  parameter int          CNT_W = 7,
  parameter logic [3:0]  SOMA  = 4'b0010
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] mul_a,
  input  logic [WIDTH-1:0] mul_b,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] product,
  input  logic [WIDTH-1:0] dp_a,
  input  logic [WIDTH-1:0] dp_b,
  input  logic [3:0]       dp_op,
  output logic [WIDTH-1:0] ula_a,
  output logic [WIDTH-1:0] ula_b,
  output logic [3:0]       ula_op,
  input  logic [WIDTH-1:0] ula_result,
  output logic [1:0]       dbg_state
);

  // Handshake: start is a level sampled only in IDLE; done is a one-cycle pulse
  // with product valid in that same cycle; busy/stall stay high through RUN and DONE.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc_next;
  logic             last_iter;
  logic             early_exit;

  assign acc_next  = mplier[0] ? ula_result : acc;
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));

`ifdef ULA_MUL_EARLY_EXIT_EN
  assign early_exit = (mplier == '0);
`else
  assign early_exit = 1'b0;
`endif

  // The ULA belongs to the multiplier only while it iterates.
  always_comb begin
    ula_a  = dp_a;
    ula_b  = dp_b;
    ula_op = dp_op;
    if (state == RUN) begin
      ula_a  = acc;
      ula_b  = mcand;
      ula_op = SOMA;
    end
  end

  assign stall     = busy;
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      product <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            mcand  <= mul_a;
            mplier <= mul_b;
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          if (early_exit) begin
            product <= acc;
            done    <= 1'b1;
            state   <= DONE;
          end else begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CNT_W'(1);
            // The final add lands in product directly, not via acc.
            if (last_iter) begin
              product <= acc_next;
              done    <= 1'b1;
              state   <= DONE;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ula_mul_seq.sv
// Self-checking bench for ula_mul_seq: directed cases plus random multiplies against a
// plain-arithmetic reference; latency model follows ULA_MUL_EARLY_EXIT_EN when defined.
module tb_ula_mul_seq;

  localparam int W = 64;
  localparam logic [3:0] SOMA = 4'b0010;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] mul_a;
  logic [W-1:0] mul_b;
  logic         busy;
  logic         stall;
  logic         done;
  logic [W-1:0] product;
  logic [W-1:0] dp_a;
  logic [W-1:0] dp_b;
  logic [3:0]   dp_op;
  logic [W-1:0] ula_a;
  logic [W-1:0] ula_b;
  logic [3:0]   ula_op;
  logic [W-1:0] ula_result;
  logic [1:0]   dbg_state;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  ula_mul_seq #(.WIDTH(W), .CNT_W(7), .SOMA(SOMA)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mul_a(mul_a), .mul_b(mul_b),
    .busy(busy), .stall(stall), .done(done), .product(product),
    .dp_a(dp_a), .dp_b(dp_b), .dp_op(dp_op),
    .ula_a(ula_a), .ula_b(ula_b), .ula_op(ula_op), .ula_result(ula_result),
    .dbg_state(dbg_state)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in ULA: add for SOMA, AND otherwise.
  always_comb begin
    ula_result = (ula_op == SOMA) ? (ula_a + ula_b) : (ula_a & ula_b);
  end

  function automatic int bitlen(input logic [W-1:0] v);
    for (int i = W - 1; i >= 0; i--) if (v[i]) return i + 1;
    return 0;
  endfunction

  // Cycles from the start cycle to the done cycle, both counted.
  function automatic int exp_latency(input logic [W-1:0] b);
    int run;
`ifdef ULA_MUL_EARLY_EXIT_EN
    run = (bitlen(b) + 1 > W) ? W : bitlen(b) + 1;
`else
    run = W;
`endif
    return run + 2;
  endfunction

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Driver: one multiply, optionally with a stray start injected at RUN cycle inj (0 = none).
  task automatic do_mul(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int inj);
    int n;
    int lat;
    int bad_run;
    bit seen;
    logic [W-1:0] exp_p;
    exp_q.push_back(a * b);
    lat = exp_latency(b);
    bad_run = 0;
    seen = 1'b0;
    mul_a = a; mul_b = b; start = 1'b1;
    n = 1;
    while (!seen && n < 200) begin
      @(posedge clk); #1;
      n++;
      start = 1'b0;
      if (done) begin
        seen = 1'b1;
        exp_p = exp_q.pop_front();
        checks++;
        if (n !== lat) begin
          errors++;
          $display("FAIL %s latency: got %0d expected %0d", name, n, lat);
        end
        checks++;
        if (product !== exp_p) begin
          errors++;
          $display("FAIL %s product: got %h expected %h", name, product, exp_p);
        end
        checks++;
        if (busy !== 1'b1 || stall !== 1'b1 || ula_op !== dp_op || ula_a !== dp_a) begin
          errors++;
          $display("FAIL %s done_cycle: busy %b stall %b ula_op %h dp_op %h", name, busy, stall,
                   ula_op, dp_op);
        end
      end else begin
        if (busy !== 1'b1 || stall !== 1'b1 || ula_op !== SOMA) bad_run++;
        if (inj != 0 && n == inj + 1) begin
          mul_a = 9; mul_b = 9; start = 1'b1;
        end
      end
    end
    mul_a = '0; mul_b = '0; start = 1'b0;
    if (!seen) begin
      void'(exp_q.pop_front());
      checks++; errors++;
      $display("FAIL %s timeout: no done after %0d cycles, expected %0d", name, n, lat);
    end
    checks++;
    if (bad_run != 0) begin
      errors++;
      $display("FAIL %s run_cycles: %0d bad cycles, expected 0", name, bad_run);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL %s after_done: done %b busy %b stall %b expected 0 0 0", name, done, busy,
               stall);
    end
  endtask

  task automatic test_reset();
    start = 1'b0; mul_a = '0; mul_b = '0;
    dp_a = 5; dp_b = 7; dp_op = 4'b0010;
    rst_n = 1'b0;
    #1;
    checks++;
    if (product !== '0 || busy !== 1'b0 || stall !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: product %h busy %b stall %b done %b expected 0", product,
               busy, stall, done);
    end
    checks++;
    if (ula_a !== 64'd5 || ula_b !== 64'd7 || ula_op !== 4'b0010) begin
      errors++;
      $display("FAIL reset_passthru: ula %0d %0d %h expected 5 7 2", ula_a, ula_b, ula_op);
    end
    apply_reset();
    dp_a = 64'h1234; dp_b = 64'h0F0F; dp_op = 4'b0111;
    #1;
    checks++;
    if (ula_a !== 64'h1234 || ula_b !== 64'h0F0F || ula_op !== 4'b0111 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_passthru: ula %h %h %h busy %b expected 1234 f0f 7 0", ula_a, ula_b,
               ula_op, busy);
    end
  endtask

  // Runs right after reset, so the product held from before is 0.
  task automatic test_reset_mid();
    int dcount;
    dcount = 0;
    mul_a = 3; mul_b = 64'h8000_0000_0000_0005; start = 1'b1;
    for (int n = 0; n < 30; n++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (done) dcount++;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || stall !== 1'b0 || done !== 1'b0 || product !== '0 || dcount != 0) begin
      errors++;
      $display("FAIL reset_mid: busy %b done %b product %h early_dones %0d expected 0 0 0 0",
               busy, done, product, dcount);
    end
    checks++;
    if (ula_op !== dp_op) begin
      errors++;
      $display("FAIL reset_mid_mux: ula_op %h expected %h", ula_op, dp_op);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_mul("after_reset_6x7", 6, 7, 0);
  endtask

  task automatic test_basic();
    do_mul("basic_3x5", 3, 5, 0);
  endtask

  task automatic test_wrap();
    do_mul("wrap_ones_x2", 64'hFFFF_FFFF_FFFF_FFFF, 2, 0);
    do_mul("wrap_msb_x2", 64'h8000_0000_0000_0000, 2, 0);
    do_mul("wrap_ones_sq", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0);
  endtask

  task automatic test_busy_start();
    int inj;
    inj = exp_latency(5) - 2;
    if (inj > 10) inj = 10;
    do_mul("busy_start", 3, 5, inj);
  endtask

  task automatic test_early();
    do_mul("early_b0", 64'hDEAD_BEEF, 0, 0);
    do_mul("early_b1", 11, 1, 0);
  endtask

  task automatic test_random();
    logic [W-1:0] a;
    logic [W-1:0] b;
    for (int i = 0; i < 16; i++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom} >> $urandom_range(0, 63);
      dp_a = {$urandom, $urandom}; dp_b = {$urandom, $urandom};
      dp_op = 4'($urandom_range(0, 15));
      do_mul("random", a, b, 0);
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_basic();
    test_wrap();
    test_busy_start();
    test_early();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
